// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: shared types, widths and the io_top register map for the Wishbone GPIO master
package wb_gpio_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam int DW = 32;
  localparam int SELW = 4;
  localparam logic [7:0] RGPIO_IN    = 8'h00;
  localparam logic [7:0] RGPIO_OUT   = 8'h04;
  localparam logic [7:0] RGPIO_OE    = 8'h08;
  localparam logic [7:0] RGPIO_INTE  = 8'h0C;
  localparam logic [7:0] RGPIO_PTRIG = 8'h10;
  localparam logic [7:0] RGPIO_AUX   = 8'h14;
  localparam logic [7:0] RGPIO_CTRL  = 8'h18;
  localparam logic [7:0] RGPIO_INTS  = 8'h1C;
  localparam logic [7:0] RGPIO_ECLK  = 8'h20;
  localparam logic [7:0] RGPIO_NEC   = 8'h24;
endpackage

// File: rtl/wb_gpio_master_if.sv
// wb_gpio_master_if: command, response and Wishbone signals of the GPIO master
interface wb_gpio_master_if #(parameter int AW = 8);
  import wb_gpio_pkg::*;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_we_i;
  logic [AW-1:0]   cmd_adr_i;
  logic [DW-1:0]   cmd_dat_i;
  logic [SELW-1:0] cmd_sel_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [DW-1:0]   rsp_dat_o;
  logic            rsp_err_o;
  logic            rsp_timeout_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [SELW-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic            busy_o;
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, busy_o
  );
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, busy_o
  );
endinterface

// File: rtl/wb_gpio_master.sv
// wb_gpio_master: single-outstanding Wishbone classic master driving the io_top GPIO registers,
// one bus cycle per command, with a watchdog that aborts a cycle nobody answers.
module wb_gpio_master #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wb_gpio_master_if.master bus
);
  import wb_gpio_pkg::*;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t          r_state, w_next;
  logic            r_cyc, r_we, r_rsp_valid, r_rsp_err, r_rsp_to;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat, r_rsp_dat;
  logic [SELW-1:0] r_sel;
  logic [CW-1:0]   r_cnt;
  logic            w_rdy, w_acc, w_bus, w_ack, w_err, w_to, w_done, w_rel;
  always_comb begin
    w_rdy  = (r_state == IDLE) & ~wb_rst_i;
    w_acc  = w_rdy & bus.cmd_valid_i;
    w_bus  = r_state == BUS;
    w_err  = w_bus & bus.wb_err_i;
    w_ack  = w_bus & bus.wb_ack_i & ~bus.wb_err_i;
    w_to   = w_bus & (TIMEOUT != 0) & (r_cnt == CW'(TIMEOUT - 1)) & ~bus.wb_ack_i & ~bus.wb_err_i;
    w_done = w_err | w_ack | w_to;
    w_rel  = (r_state == RESP) & r_rsp_valid & bus.rsp_ready_i;
    w_next = w_acc ? BUS : w_done ? RESP : w_rel ? IDLE : r_state;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_cyc <= 1'b1;
        r_we  <= bus.cmd_we_i;
        r_adr <= bus.cmd_adr_i;
        r_dat <= bus.cmd_we_i ? bus.cmd_dat_i : '0;
        r_sel <= bus.cmd_sel_i;
        r_cnt <= '0;
      end
      if (w_bus && ~&r_cnt)
        r_cnt <= r_cnt + 1'b1;
      // ack, err and timeout all close the cycle; only an ack on a read returns data
      if (w_done) begin
        r_cyc       <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_dat   <= (w_ack && !r_we) ? bus.wb_dat_i : '0;
        r_rsp_err   <= w_err;
        r_rsp_to    <= w_to;
      end
      if (w_rel)
        r_rsp_valid <= 1'b0;
    end
  end
  assign bus.cmd_ready_o   = w_rdy;
  assign bus.wb_cyc_o      = r_cyc;
  assign bus.wb_stb_o      = r_cyc;
  assign bus.wb_we_o       = r_we;
  assign bus.wb_adr_o      = r_adr;
  assign bus.wb_dat_o      = r_dat;
  assign bus.wb_sel_o      = r_sel;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_dat_o     = r_rsp_dat;
  assign bus.rsp_err_o     = r_rsp_err;
  assign bus.rsp_timeout_o = r_rsp_to;
  assign bus.busy_o        = r_state != IDLE;
endmodule

// File: tb/tb_wb_gpio_master.sv
// tb_wb_gpio_master: scoreboard bench with a Wishbone slave model standing in for io_top
module tb_wb_gpio_master;
  import wb_gpio_pkg::*;
  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } exp_t;
  logic clk, rst;
  int   n_chk, n_pass;
  int   s_lat, s_mode;
  exp_t sb[$];
  wb_gpio_master_if #(.AW(8)) bus();
  wb_gpio_master #(.AW(8), .DW(32), .TIMEOUT(16)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  // slave: s_mode 0 acks, 1 acks with err, 2 never answers; s_lat extra wait cycles
  initial begin
    logic [31:0] smem [0:15];
    int s_cnt;
    for (int i = 0; i < 16; i++) smem[i] = 32'h0;
    smem[0] = 32'h0000_0001;
    smem[2] = 32'h0000_00F0;
    s_cnt = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i && !bus.wb_err_i) begin
        if (s_cnt < s_lat) s_cnt++;
        else if (s_mode == 0) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = bus.wb_we_o ? 32'h5A5A_5A5A : smem[bus.wb_adr_o[5:2]];
          if (bus.wb_we_o)
            for (int b = 0; b < 4; b++)
              if (bus.wb_sel_o[b]) smem[bus.wb_adr_o[5:2]][8*b +: 8] = bus.wb_dat_o[8*b +: 8];
        end else if (s_mode == 1) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_err_i = 1'b1;
          bus.wb_dat_i = 32'hDEAD_BEEF;
        end
      end else begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = 32'hFFFF_FFFF;
        s_cnt = 0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_dat", bus.rsp_dat_o, e.dat);
          chk("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
          chk("rsp_timeout", 32'(bus.rsp_timeout_o), 32'(e.to));
        end
      end
    end
  end
  task automatic send(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] e_dat, input logic e_err,
                      input logic e_to);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        sb.push_back('{dat: e_dat, err: e_err, to: e_to});
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        return;
      end
    end
    chk("cmd_accept", 0, 1);
    bus.cmd_valid_i = 1'b0;
  endtask
  task automatic wait_rsp(output int n_cyc, output int n_clk);
    n_cyc = 0;
    n_clk = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_clk++;
      if (bus.rsp_valid_o) return;
      if (bus.wb_cyc_o) n_cyc++;
    end
    chk("rsp_wait", 0, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end
  initial begin
    int nc, nk;
    logic seen;
    n_chk = 0;
    n_pass = 0;
    s_lat = 0;
    s_mode = 0;
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i = 1'b0;
    bus.cmd_adr_i = '0;
    bus.cmd_dat_i = '0;
    bus.cmd_sel_i = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 0);
    chk("rst_stb", 32'(bus.wb_stb_o), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 0);
    chk("rst_rsp_dat", bus.rsp_dat_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready_o), 1);
    // write with one wait cycle from the slave
    s_lat = 1;
    send(1'b1, RGPIO_OUT, 32'h0000_00A5, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wr_cyc", 32'(bus.wb_cyc_o), 1);
    chk("wr_stb", 32'(bus.wb_stb_o), 1);
    chk("wr_we", 32'(bus.wb_we_o), 1);
    chk("wr_adr", 32'(bus.wb_adr_o), 32'h04);
    chk("wr_dat", bus.wb_dat_o, 32'hA5);
    chk("wr_sel", 32'(bus.wb_sel_o), 32'hF);
    chk("wr_busy", 32'(bus.busy_o), 1);
    chk("wr_cmd_ready", 32'(bus.cmd_ready_o), 0);
    @(negedge clk);
    chk("wr_adr_hold", 32'(bus.wb_adr_o), 32'h04);
    chk("wr_dat_hold", bus.wb_dat_o, 32'hA5);
    wait_rsp(nc, nk);
    chk("wr_rsp_lat", nk, 1);
    chk("wr_cyc_drop", 32'(bus.wb_cyc_o), 0);
    // read of the input register, answered immediately
    s_lat = 0;
    send(1'b0, RGPIO_IN, 32'hFFFF_FFFF, 4'hF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("rd_cyc", 32'(bus.wb_cyc_o), 1);
    chk("rd_we", 32'(bus.wb_we_o), 0);
    chk("rd_dat_o", bus.wb_dat_o, 0);
    chk("rd_adr", 32'(bus.wb_adr_o), 32'h00);
    wait_rsp(nc, nk);
    chk("rd_rsp_lat", nk, 1);
    // ack and err together: err must win
    s_mode = 1;
    send(1'b0, 8'h30, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
    wait_rsp(nc, nk);
    chk("err_cyc_drop", 32'(bus.wb_cyc_o), 0);
    chk("err_stb_drop", 32'(bus.wb_stb_o), 0);
    chk("err_lat", nk, 2);
    // silent slave: watchdog closes after exactly TIMEOUT cycles
    s_mode = 2;
    send(1'b0, RGPIO_PTRIG, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_rsp(nc, nk);
    chk("to_cyc_cycles", nc, 16);
    chk("to_rsp_lat", nk, 17);
    s_mode = 0;
    send(1'b0, RGPIO_OE, 32'h0, 4'hF, 32'h0000_00F0, 1'b0, 1'b0);
    wait_rsp(nc, nk);
    chk("after_to_lat", nk, 2);
    // response backpressure with a second command waiting
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    send(1'b0, RGPIO_OUT, 32'h0, 4'hF, 32'h0000_00A5, 1'b0, 1'b0);
    wait_rsp(nc, nk);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = RGPIO_IN;
    bus.cmd_sel_i   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 1);
      chk("bp_rsp_dat", bus.rsp_dat_o, 32'hA5);
      chk("bp_cmd_ready", 32'(bus.cmd_ready_o), 0);
      chk("bp_cyc", 32'(bus.wb_cyc_o), 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.cmd_ready_o), 0);
    @(negedge clk);
    chk("bp_accept_ready", 32'(bus.cmd_ready_o), 1);
    if (bus.cmd_ready_o) sb.push_back('{dat: 32'h0000_0001, err: 1'b0, to: 1'b0});
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_second_cyc", 32'(bus.wb_cyc_o), 1);
    wait_rsp(nc, nk);
    // reset during the second BUS cycle discards the transaction
    s_mode = 2;
    send(1'b0, RGPIO_AUX, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc_before", 32'(bus.wb_cyc_o), 1);
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_cyc", 32'(bus.wb_cyc_o), 0);
    chk("mid_rst_stb", 32'(bus.wb_stb_o), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready_o), 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o || bus.wb_cyc_o) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 0);
    s_mode = 0;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_gpio_master.md
Name: wb_gpio_master

Overview:
Single-outstanding Wishbone classic-cycle master that drives the register interface of io_top (the GPIO core).
Accepts register read/write commands on a valid/ready command port and runs one Wishbone cycle per command. It returns read data and status on a valid/ready response port.
Sits directly upstream of io_top in the GPIO subsystem, between the test/CPU-side command source and the GPIO slave.
Includes a bus-timeout watchdog so a missing ack cannot hang the subsystem.

Parameters:
AW, 8, Wishbone address width (byte address into GPIO register space)
DW, 32, data width; fixed at 32, no other value supported
TIMEOUT, 16, max cycles in BUS with no ack/err before abort; 0 disables the watchdog

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  master can accept a command
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  AW  register byte address
cmd_dat_i  in  32  write data
cmd_sel_i  in  4  byte selects
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed
rsp_dat_o  out  32  read data (0 for writes/errors/timeouts)
rsp_err_o  out  1  slave signalled wb_err
rsp_timeout_o  out  1  watchdog expired
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  AW  address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects
wb_dat_i  in  32  read data from io_top
wb_ack_i  in  1  ack from io_top
wb_err_i  in  1  error from io_top
busy_o  out  1  state != IDLE

Behaviour:
- Reset:
  - State goes to IDLE.
  - All wb_* outputs, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o, busy_o and the watchdog counter are 0.
  - cmd_ready_o is 0 while wb_rst_i=1.
- FSM states are IDLE, BUS and RESP. All Wishbone and response outputs are registered.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o, latch we/adr/dat/sel and move to BUS.
  - wb_cyc_o=wb_stb_o=1 from the next cycle.
  - wb_dat_o is driven 0 for reads.
- BUS:
  - cyc/stb/we/adr/dat/sel are held stable.
  - The watchdog counts cycles spent in BUS.
  - wb_ack_i=1 and wb_err_i=0: capture wb_dat_i for a read (0 for a write), err=0, timeout=0.
  - wb_err_i=1: err=1, dat=0. When ack and err arrive in the same cycle, err wins.
  - TIMEOUT!=0 and count reaches TIMEOUT-1 with no ack/err: timeout=1, dat=0.
  - Any of these three events drops cyc/stb at the next edge, moves to RESP and asserts rsp_valid_o in that same edge.
- RESP:
  - rsp_* is held stable until rsp_valid_o&rsp_ready_i, then the master returns to IDLE.
  - rsp_valid_o drops and cmd_ready_o rises in the following cycle.
- Latency:
  - Command accepted at edge N gives cyc/stb high in cycle N+1.
  - Ack in cycle N+k gives rsp_valid_o high in cycle N+k+1.
  - Minimum command-to-command spacing is 3 cycles when rsp_ready_i is held high.
- Only one transaction is outstanding; there is no pipelining and no burst (CTI/BTE not supported).
- wb_ack_i/wb_err_i while not in BUS: ignored, no state change.
- cmd_valid_i while not in IDLE: not accepted; the source must hold the command.
- Reset mid-transaction: cyc/stb drop at the reset edge and any pending response is discarded.
- Watchdog width is $clog2(TIMEOUT+1). The counter is cleared on entry to BUS and never wraps.

Decomposition:
- Package wb_gpio_pkg holds:
  - the state enum typedef (IDLE, BUS, RESP);
  - DW=32 and SELW=4;
  - GPIO register byte offsets as constants: RGPIO_IN 0x00, RGPIO_OUT 0x04, RGPIO_OE 0x08, RGPIO_INTE 0x0C, RGPIO_PTRIG 0x10, RGPIO_AUX 0x14, RGPIO_CTRL 0x18, RGPIO_INTS 0x1C, RGPIO_ECLK 0x20, RGPIO_NEC 0x24.
- No sub-module. The watchdog counter stays inline.

Test Plan:
- Write: cmd we=1 adr=0x04 dat=0x0000_00A5 sel=0xF; slave acks 1 cycle after stb -> wb_adr_o=0x04 and wb_dat_o=0xA5 stable until ack; rsp_valid_o two cycles after ack-cycle start, err=0, timeout=0, dat=0.
- Read: preload RGPIO_IN pin=1, cmd we=0 adr=0x00 -> rsp_dat_o=0x0000_0001, err=0; wb_we_o=0 and wb_dat_o=0 throughout the cycle.
- Error: slave asserts ack and err together on adr=0x30 -> rsp_err_o=1, rsp_dat_o=0, cyc/stb deasserted the next cycle.
- Timeout: TIMEOUT=16, slave never acks -> cyc/stb high exactly 16 cycles, then rsp_timeout_o=1, dat=0; a later read of 0x08 completes normally.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with a second cmd_valid_i pending -> rsp_* stable, cmd_ready_o=0, wb_cyc_o=0; second command accepted the cycle after release.
- Reset: assert wb_rst_i in the second BUS cycle -> cyc/stb=0 next edge, no rsp_valid_o, cmd_ready_o=1 the cycle after reset deasserts.
